// File: rtl/m_dram_app_responder.sv
// Behavioural DRAM app-interface responder: byte-masked beat memory, write-data FIFO, fixed-latency
// reads. Define DRAM_RESP_BACKPRESSURE_EN to drop o_app_rdy one cycle in every eight.
module m_dram_app_responder #(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_CMD_WIDTH  = 3,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned CALIB_CYCLES   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [APP_ADDR_WIDTH-1:0] i_app_addr,
  input  logic [APP_CMD_WIDTH-1:0]  i_app_cmd,
  input  logic                      i_app_en,
  output logic                      o_app_rdy,
  input  logic [APP_DATA_WIDTH-1:0] i_app_wdf_data,
  input  logic [APP_MASK_WIDTH-1:0] i_app_wdf_mask,
  input  logic                      i_app_wdf_wren,
  input  logic                      i_app_wdf_end,
  output logic                      o_app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0] o_app_rd_data,
  output logic                      o_app_rd_data_valid,
  output logic                      o_app_rd_data_end,
  output logic                      o_init_calib_complete
);

  localparam int unsigned MemDepth = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned CalW     = $clog2(CALIB_CYCLES + 1);
  localparam logic [APP_CMD_WIDTH-1:0] CmdWrite = APP_CMD_WIDTH'(0);
  localparam logic [APP_CMD_WIDTH-1:0] CmdRead  = APP_CMD_WIDTH'(1);

  typedef enum logic {StIdle, StPend} state_e;

  state_e state_q, state_d;

  logic [CalW-1:0] cal_cnt_q, cal_cnt_d;
  logic            calib_q, calib_d;

  logic [APP_DATA_WIDTH-1:0] fifo_data_q [4];
  logic [APP_MASK_WIDTH-1:0] fifo_mask_q [4];
  logic [1:0]                fifo_rd_q, fifo_rd_d;
  logic [1:0]                fifo_wr_q, fifo_wr_d;
  logic [2:0]                fifo_cnt_q, fifo_cnt_d;
  logic                      fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic [MEM_DEPTH_LOG2-1:0] pend_idx_q, pend_idx_d;
  logic [MEM_DEPTH_LOG2-1:0] cmd_idx, commit_idx;
  logic [APP_DATA_WIDTH-1:0] commit_data;
  logic [APP_MASK_WIDTH-1:0] commit_mask;
  logic                      commit;

  logic [APP_DATA_WIDTH-1:0] mem_q [MemDepth];

  logic                      rd_vld_q [RD_LATENCY];
  logic [APP_DATA_WIDTH-1:0] rd_dat_q [RD_LATENCY];

  logic bp_block, app_rdy, wdf_rdy, wdf_acc, cmd_acc, is_wr, is_rd;

  // Only the beat index matters; the rest of the address and wdf_end are don't-cares.
  logic unused_inputs;
  assign unused_inputs = ^{i_app_wdf_end, i_app_addr};

`ifdef DRAM_RESP_BACKPRESSURE_EN
  logic [2:0] bp_cnt_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) bp_cnt_q <= 3'd0;
    else       bp_cnt_q <= bp_cnt_q + 3'd1;
  end
  assign bp_block = (bp_cnt_q == 3'd7);
`else
  assign bp_block = 1'b0;
`endif

  assign cmd_idx    = i_app_addr[3 +: MEM_DEPTH_LOG2];
  assign fifo_empty = (fifo_cnt_q == 3'd0);
  assign fifo_full  = (fifo_cnt_q == 3'd4);
  assign wdf_rdy    = calib_q & ~fifo_full;
  assign wdf_acc    = i_app_wdf_wren & wdf_rdy;
  assign app_rdy    = calib_q & (state_q == StIdle) & ~bp_block;
  assign cmd_acc    = i_app_en & app_rdy;
  assign is_wr      = cmd_acc & (i_app_cmd == CmdWrite);
  assign is_rd      = cmd_acc & (i_app_cmd == CmdRead);

  always_comb begin
    cal_cnt_d = cal_cnt_q;
    calib_d   = calib_q;
    if (!calib_q) begin
      cal_cnt_d = cal_cnt_q + CalW'(1);
      if (cal_cnt_q == CalW'(CALIB_CYCLES - 1)) calib_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    commit     = 1'b0;
    commit_idx = cmd_idx;
    unique case (state_q)
      StIdle: begin
        if (is_wr) begin
          if (!fifo_empty || wdf_acc) begin
            commit = 1'b1;
          end else begin
            state_d    = StPend;
            pend_idx_d = cmd_idx;
          end
        end
      end
      StPend: begin
        commit_idx = pend_idx_q;
        if (wdf_acc) begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A commit on an empty FIFO takes the incoming beat directly instead of storing it.
  always_comb begin
    fifo_pop    = commit & ~fifo_empty;
    fifo_push   = wdf_acc & ~(commit & fifo_empty);
    commit_data = fifo_pop ? fifo_data_q[fifo_rd_q] : i_app_wdf_data;
    commit_mask = fifo_pop ? fifo_mask_q[fifo_rd_q] : i_app_wdf_mask;
    fifo_rd_d   = fifo_rd_q + 2'(fifo_pop);
    fifo_wr_d   = fifo_wr_q + 2'(fifo_push);
    fifo_cnt_d  = fifo_cnt_q + 3'(fifo_push) - 3'(fifo_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cal_cnt_q  <= '0;
      calib_q    <= 1'b0;
      pend_idx_q <= '0;
      fifo_rd_q  <= 2'd0;
      fifo_wr_q  <= 2'd0;
      fifo_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      cal_cnt_q  <= cal_cnt_d;
      calib_q    <= calib_d;
      pend_idx_q <= pend_idx_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && fifo_push) begin
      fifo_data_q[fifo_wr_q] <= i_app_wdf_data;
      fifo_mask_q[fifo_wr_q] <= i_app_wdf_mask;
    end
  end

  // Memory has no reset so contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (!i_rst && commit) begin
      for (int unsigned b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!commit_mask[b]) mem_q[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  // Data stages load only with their valid, so the last stage holds between responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= 1'b0;
        rd_dat_q[i] <= '0;
      end
    end else begin
      rd_vld_q[0] <= is_rd;
      if (is_rd) rd_dat_q[0] <= mem_q[cmd_idx];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        if (rd_vld_q[i-1]) rd_dat_q[i] <= rd_dat_q[i-1];
      end
    end
  end

  assign o_app_rdy             = app_rdy;
  assign o_app_wdf_rdy         = wdf_rdy;
  assign o_app_rd_data         = rd_dat_q[RD_LATENCY-1];
  assign o_app_rd_data_valid   = rd_vld_q[RD_LATENCY-1];
  assign o_app_rd_data_end     = rd_vld_q[RD_LATENCY-1];
  assign o_init_calib_complete = calib_q;

endmodule

// File: tb/tb_m_dram_app_responder.sv
// Scoreboard bench for m_dram_app_responder: randomized traffic against a beat-level memory model.
module tb_m_dram_app_responder;

  localparam int RDL = 4;
  localparam int CAL = 16;
  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [27:0]  i_app_addr = '0;
  logic [2:0]   i_app_cmd = '0;
  logic         i_app_en = 1'b0;
  logic         o_app_rdy;
  logic [127:0] i_app_wdf_data = '0;
  logic [15:0]  i_app_wdf_mask = '0;
  logic         i_app_wdf_wren = 1'b0;
  logic         i_app_wdf_end = 1'b0;
  logic         o_app_wdf_rdy;
  logic [127:0] o_app_rd_data;
  logic         o_app_rd_data_valid;
  logic         o_app_rd_data_end;
  logic         o_init_calib_complete;

  m_dram_app_responder dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_app_addr            (i_app_addr),
    .i_app_cmd             (i_app_cmd),
    .i_app_en              (i_app_en),
    .o_app_rdy             (o_app_rdy),
    .i_app_wdf_data        (i_app_wdf_data),
    .i_app_wdf_mask        (i_app_wdf_mask),
    .i_app_wdf_wren        (i_app_wdf_wren),
    .i_app_wdf_end         (i_app_wdf_end),
    .o_app_wdf_rdy         (o_app_wdf_rdy),
    .o_app_rd_data         (o_app_rd_data),
    .o_app_rd_data_valid   (o_app_rd_data_valid),
    .o_app_rd_data_end     (o_app_rd_data_end),
    .o_init_calib_complete (o_init_calib_complete)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           vld_seen = 0;
  exp_t         exp_q[$];
  logic [127:0] mem_m [1024];
  logic [127:0] dq_d[$];
  logic [15:0]  dq_m[$];
  int           wq[$];
  logic [127:0] last_data = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [27:0] a);
    return int'(a[12:3]);
  endfunction

  function automatic logic [27:0] rand_addr(input int idx);
    logic [27:0] a;
    a = 28'($urandom);
    a[12:3] = 10'(idx);
    return a;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Pair oldest accepted data beats with oldest accepted write commands, in order.
  task automatic drain_model();
    logic [127:0] d;
    logic [15:0]  m;
    int           i;
    while (dq_d.size() > 0 && wq.size() > 0) begin
      d = dq_d.pop_front();
      m = dq_m.pop_front();
      i = wq.pop_front();
      for (int b = 0; b < 16; b++) if (!m[b]) mem_m[i][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic step(input bit en, input logic [2:0] cmd, input logic [27:0] addr, input bit wren,
                      input logic [127:0] d, input logic [15:0] m, output bit acc_c,
                      output bit acc_w);
    exp_t e;
    @(negedge i_clk);
    i_app_en = en;
    i_app_cmd = cmd;
    i_app_addr = addr;
    i_app_wdf_wren = wren;
    i_app_wdf_end = wren;
    i_app_wdf_data = d;
    i_app_wdf_mask = m;
    #1;
    acc_c = en && o_app_rdy;
    acc_w = wren && o_app_wdf_rdy;
    if (acc_w) begin
      dq_d.push_back(d);
      dq_m.push_back(m);
    end
    if (acc_c && cmd == WR) wq.push_back(idx_of(addr));
    drain_model();
    if (acc_c && cmd == RD) begin
      e.data = mem_m[idx_of(addr)];
      e.cyc = cyc + RDL;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    bit ac, aw;
    repeat (n) step(1'b0, WR, '0, 1'b0, '0, '0, ac, aw);
  endtask

  task automatic send(input bit with_c, input logic [2:0] cmd, input logic [27:0] addr,
                      input bit with_d, input logic [127:0] d, input logic [15:0] m);
    bit ac, aw;
    bit need_c = with_c;
    bit need_w = with_d;
    int n = 0;
    while ((need_c || need_w) && n < 32) begin
      step(need_c, cmd, addr, need_w, d, m, ac, aw);
      if (ac) need_c = 1'b0;
      if (aw) need_w = 1'b0;
      n++;
    end
    check("send_accept", {126'd0, need_c, need_w}, '0);
  endtask

  task automatic do_reset();
    int n = 0;
    bit done = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    i_app_en = 1'b0;
    i_app_wdf_wren = 1'b0;
    i_app_wdf_end = 1'b0;
    exp_q.delete();
    dq_d.delete();
    dq_m.delete();
    wq.delete();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_rd_valid", o_app_rd_data_valid, 0);
    check("rst_rd_end", o_app_rd_data_end, 0);
    check("rst_rd_data", o_app_rd_data, 0);
    check("rst_calib", o_init_calib_complete, 0);
    check("rst_app_rdy", o_app_rdy, 0);
    check("rst_wdf_rdy", o_app_wdf_rdy, 0);
    while (!done && n < 40) begin
      @(negedge i_clk);
      #1;
      n++;
      if (o_init_calib_complete) begin
        done = 1'b1;
      end else begin
        check("precal_app_rdy", o_app_rdy, 0);
        check("precal_wdf_rdy", o_app_wdf_rdy, 0);
      end
    end
    check("calib_cycles", 128'(n), 128'(CAL));
  endtask

  // Monitor: pops the scoreboard whenever a read beat is presented.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      last_data = '0;
    end else begin
      check("rd_end_eq_valid", o_app_rd_data_end, o_app_rd_data_valid);
      if (o_app_rd_data_valid) begin
        vld_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", o_app_rd_data, e.data);
          check("rd_latency", 128'(cyc), 128'(e.cyc));
        end
        last_data = o_app_rd_data;
      end else begin
        check("rd_data_hold", o_app_rd_data, last_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ac, aw;
    bit en, wren;
    logic [2:0] cmd;
    int r, lows, vb, guard;

    do_reset();

    for (int i = 0; i < 16; i++) send(1'b1, WR, 28'(i << 3), 1'b1, rand128(), 16'h0000);

    // Command and data in the same cycle, then read back.
    send(1'b1, WR, 28'h0000008, 1'b1, {96'h0123456789ABCDEF01234567, 32'hDEADBEEF}, 16'h0000);
    send(1'b1, RD, 28'h0000008, 1'b0, '0, '0);
    idle(RDL + 2);

    // Command without data parks the responder until the beat arrives.
    send(1'b1, WR, 28'h0000010, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, WR, '0, 1'b0, '0, '0, ac, aw);
      check("pend_app_rdy", o_app_rdy, 0);
    end
    send(1'b0, WR, '0, 1'b1, rand128(), 16'h0000);
    send(1'b1, RD, 28'h0000010, 1'b0, '0, '0);

    // Only byte 0 of beat 0 written.
    send(1'b1, WR, 28'h0000000, 1'b1, 128'hAA, 16'hFFFE);
    send(1'b1, RD, 28'h0000000, 1'b0, '0, '0);

    // Data ahead of commands, plus an ignored command code.
    for (int i = 0; i < 3; i++) send(1'b0, WR, '0, 1'b1, rand128(), 16'(i * 16'h0F0F));
    for (int i = 0; i < 3; i++) send(1'b1, WR, rand_addr(4 + i), 1'b0, '0, '0);
    send(1'b1, 3'b010, rand_addr(7), 1'b0, '0, '0);
    for (int i = 4; i < 8; i++) send(1'b1, RD, rand_addr(i), 1'b0, '0, '0);

    // Back-to-back reads.
    send(1'b1, RD, 28'h0000000, 1'b0, '0, '0);
    send(1'b1, RD, 28'h0000008, 1'b0, '0, '0);
    send(1'b1, RD, 28'h0000010, 1'b0, '0, '0);
    idle(RDL + 2);

    for (int k = 0; k < 400; k++) begin
      en = ($urandom % 4) != 0;
      r = int'($urandom % 10);
      cmd = (r < 4) ? WR : (r < 8) ? RD : 3'(2 + $urandom % 6);
      wren = (wq.size() > 0) || ($urandom % 2 == 1);
      step(en, cmd, rand_addr(int'($urandom % 16)), wren, rand128(),
           ($urandom % 3 == 0) ? 16'($urandom) : 16'h0000, ac, aw);
    end
    guard = 0;
    while (wq.size() > 0 && guard < 16) begin
      step(1'b0, WR, '0, 1'b1, rand128(), 16'h0000, ac, aw);
      guard++;
    end
    check("pending_writes_done", 128'(wq.size()), 0);
    idle(RDL + 2);

    // Continuous read traffic: count cycles with o_app_rdy low.
    lows = 0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, RD, rand_addr(int'($urandom % 16)), 1'b0, '0, '0, ac, aw);
      if (!o_app_rdy) lows++;
    end
`ifdef DRAM_RESP_BACKPRESSURE_EN
    check("rdy_low_cycles", 128'(lows), 128'(8));
`else
    check("rdy_low_cycles", 128'(lows), 128'(0));
`endif
    idle(RDL + 2);

    // Reset with reads in flight: nothing may emerge afterwards, memory survives.
    send(1'b1, RD, 28'h0000000, 1'b0, '0, '0);
    send(1'b1, RD, 28'h0000008, 1'b0, '0, '0);
    send(1'b1, RD, 28'h0000010, 1'b0, '0, '0);
    vb = vld_seen;
    do_reset();
    check("no_valid_after_reset", 128'(vld_seen - vb), 0);
    send(1'b1, RD, 28'h0000010, 1'b0, '0, '0);
    send(1'b1, RD, 28'h0000000, 1'b0, '0, '0);
    idle(RDL + 4);
    check("scoreboard_empty", 128'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_dram_app_responder.md
M_DRAM_APP_RESPONDER -- requirements
Module: m_dram_app_responder

Interface
REQ-001 Parameter APP_ADDR_WIDTH, default 28, app address width.
REQ-002 Parameter APP_CMD_WIDTH, default 3, command width.
REQ-003 Parameter APP_DATA_WIDTH, default 128, data beat width.
REQ-004 Parameter APP_MASK_WIDTH, default 16, byte mask width (APP_DATA_WIDTH/8).
REQ-005 Parameter MEM_DEPTH_LOG2, default 10, log2 of beat count stored.
REQ-006 Parameter RD_LATENCY, default 4 (range 1..15), cycles from read acceptance to data valid.
REQ-007 Parameter CALIB_CYCLES, default 16, cycles from reset release to calibration complete.
REQ-008 i_clk  in  1  clock; all logic on rising edge.
REQ-009 i_rst  in  1  synchronous active-high reset.
REQ-010 i_app_addr  in  APP_ADDR_WIDTH  command address, 16-bit-word granular.
REQ-011 i_app_cmd  in  APP_CMD_WIDTH  3'b000 write, 3'b001 read.
REQ-012 i_app_en  in  1  command valid.
REQ-013 o_app_rdy  out  1  command accepted when i_app_en & o_app_rdy.
REQ-014 i_app_wdf_data  in  APP_DATA_WIDTH  write beat.
REQ-015 i_app_wdf_mask  in  APP_MASK_WIDTH  bit=1 means byte NOT written.
REQ-016 i_app_wdf_wren, i_app_wdf_end  in  1 each  write data valid / last beat (always 1, single-beat).
REQ-017 o_app_wdf_rdy  out  1  write data accepted when i_app_wdf_wren & o_app_wdf_rdy.
REQ-018 o_app_rd_data  out  APP_DATA_WIDTH  read beat.
REQ-019 o_app_rd_data_valid, o_app_rd_data_end  out  1 each  read beat valid / last (end equals valid).
REQ-020 o_init_calib_complete  out  1  responder ready for traffic.

Function
REQ-021 Beat index SHALL be i_app_addr[3 +: MEM_DEPTH_LOG2]; bits [2:0] and upper bits ignored (aliasing).
REQ-022 Calibration counter SHALL hold o_init_calib_complete low for exactly CALIB_CYCLES cycles after reset release, then high until next reset.
REQ-023 o_app_rdy and o_app_wdf_rdy SHALL be 0 while calibration incomplete.
REQ-024 Write data SHALL enter a 4-entry FIFO; o_app_wdf_rdy = calib & FIFO not full; data may precede its command by up to 4 beats.
REQ-025 Write command accepted with FIFO non-empty or same-cycle wdf accept SHALL commit the oldest beat to memory that cycle, bytes merged per mask.
REQ-026 Write command accepted with no data available SHALL enter PEND state: o_app_rdy=0 until a beat is accepted, commit on that cycle, return to IDLE.
REQ-027 Read accepted in cycle N SHALL assert o_app_rd_data_valid in cycle N+RD_LATENCY with the memory beat as of after all earlier-accepted writes commit.
REQ-028 Reads SHALL be fully pipelined: one read per cycle, responses in acceptance order, no gaps added.
REQ-029 Other command codes SHALL be accepted and ignored (no response, no write).
REQ-030 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; pop on empty with same-cycle push SHALL bypass.
REQ-031 o_app_rd_data SHALL hold its last value when valid is 0.

Reset
REQ-032 On i_rst: o_app_rdy=0, o_app_wdf_rdy=0, o_app_rd_data_valid=0, o_app_rd_data_end=0, o_init_calib_complete=0, o_app_rd_data=0, FIFO empty, state IDLE, calib counter 0.
REQ-033 Reset mid-operation SHALL drop in-flight reads (no valid after reset) and pending writes; memory contents SHALL be retained.

Configuration
REQ-034 Macro DRAM_RESP_BACKPRESSURE_EN defined: a free-running 3-bit counter SHALL force o_app_rdy=0 when counter==7 (one cycle in eight) in addition to REQ-023/026.
REQ-035 Macro undefined: o_app_rdy governed only by REQ-023/026; no counter logic present.

Verification
REQ-036 Reset then idle -> o_init_calib_complete rises exactly 16 cycles after i_rst falls; rdy signals 0 before.
REQ-037 Write addr 0x08, data 0x..DEADBEEF, mask 0 with cmd+data same cycle; read 0x08 -> valid 4 cycles after read accept, data 0x..DEADBEEF.
REQ-038 Write cmd addr 0x10 with no data, data 3 cycles later -> o_app_rdy 0 for those cycles, read 0x10 returns data.
REQ-039 Masked write mask 16'hFFFE data 0xAA over beat 0 -> only byte 0 becomes 0xAA.
REQ-040 Back-to-back reads 0x00,0x08,0x10 -> three consecutive valid cycles in order; assert i_rst during them -> no valid after reset.
REQ-041 With DRAM_RESP_BACKPRESSURE_EN, continuous i_app_en -> o_app_rdy low one cycle in every eight, no command lost.
